seg_scan_capture: RTL and testbench

//  Receive side of the multiplexed 7-segment display interface: watches active-low anode and

---
 rtl/seg_scan_capture.sv | 136 +++++++++++++
 tb/tb_seg_scan_capture.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_capture.sv
// Display monitor: watches the multiplexed 7-segment anode/cathode lines
// and rebuilds each digit's hex value, decimal point and freshness.
module seg_scan_capture #(
    parameter int N_DIG       = 4,
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk_out,
    input  logic               rst,
    input  logic [N_DIG-1:0]   an_n,
    input  logic [6:0]         seg_n,
    input  logic               dp_n,
    output logic [4*N_DIG-1:0] digit_code,
    output logic [N_DIG-1:0]   digit_dp,
    output logic [N_DIG-1:0]   digit_valid,
    output logic               frame_done,
    output logic               err_multi
);
    localparam int SW  = N_DIG + 8;
    localparam int SBW = $clog2(STABLE_CYC + 1);
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SBW-1:0] STAB_FIRE = SBW'(STABLE_CYC - 1);
    localparam logic [SBW-1:0] STAB_MAX  = SBW'(STABLE_CYC);
    localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0]  TMO_MAX   = TW'(TIMEOUT_CYC);

    logic [SW-1:0]    s_q;
    logic [SW-1:0]    p_q;
    logic [SBW-1:0]   stab;
    logic             armed;
    logic [N_DIG-1:0] done_mask;
    logic [N_DIG-1:0] mask_next;
    logic [TW-1:0]    tmo [N_DIG];

    logic             same;
    logic             cap;
    logic             one_low;
    logic             multi_low;
    logic             code_ok;
    logic [N_DIG-1:0] lows;
    logic [N_DIG-1:0] slot_hit;
    logic [6:0]       segs;
    logic [3:0]       code_val;

    assign same      = (s_q == p_q);
    assign cap       = armed && (stab == STAB_FIRE);
    assign lows      = ~p_q[SW-1 -: N_DIG];
    assign segs      = ~p_q[7:1];
    assign one_low   = (lows != '0) && ((lows & (lows - N_DIG'(1))) == '0);
    assign multi_low = (lows != '0) && !one_low;
    assign slot_hit  = (cap && one_low) ? lows : '0;

    always_comb begin
        code_ok  = 1'b1;
        code_val = 4'h0;
        case (segs)
            7'h3F: code_val = 4'h0;
            7'h06: code_val = 4'h1;
            7'h5B: code_val = 4'h2;
            7'h4F: code_val = 4'h3;
            7'h66: code_val = 4'h4;
            7'h6D: code_val = 4'h5;
            7'h7D: code_val = 4'h6;
            7'h07: code_val = 4'h7;
            7'h7F: code_val = 4'h8;
            7'h6F: code_val = 4'h9;
            7'h77: code_val = 4'hA;
            7'h7C: code_val = 4'hB;
            7'h39: code_val = 4'hC;
            7'h5E: code_val = 4'hD;
            7'h79: code_val = 4'hE;
            7'h71: code_val = 4'hF;
            default: code_ok = 1'b0;
        endcase
    end

    // A completed frame clears the mask, but a capture on that edge still counts.
    always_comb begin
        mask_next = (&done_mask) ? '0 : done_mask;
        if (code_ok) begin
            mask_next = mask_next | slot_hit;
        end
    end

    always_ff @(posedge clk_out) begin
        if (rst) begin
            s_q         <= '1;
            p_q         <= '1;
            stab        <= '0;
            armed       <= 1'b0;
            done_mask   <= '0;
            digit_code  <= '0;
            digit_dp    <= '0;
            digit_valid <= '0;
            frame_done  <= 1'b0;
            err_multi   <= 1'b0;
            for (int k = 0; k < N_DIG; k++) begin
                tmo[k] <= '0;
            end
        end else begin
            s_q <= {an_n, seg_n, dp_n};
            p_q <= s_q;
            if (!same) begin
                stab  <= '0;
                armed <= 1'b1;
            end else begin
                if (stab != STAB_MAX) begin
                    stab <= stab + SBW'(1);
                end
                if (cap) begin
                    armed <= 1'b0;
                end
            end
            err_multi  <= cap && multi_low;
            frame_done <= &done_mask;
            done_mask  <= mask_next;
            for (int k = 0; k < N_DIG; k++) begin
                if (slot_hit[k]) begin
                    digit_dp[k]          <= ~p_q[0];
                    digit_code[4*k +: 4] <= code_ok ? code_val : 4'h0;
                    digit_valid[k]       <= code_ok;
                    if (code_ok) begin
                        tmo[k] <= '0;
                    end
                end else if (digit_valid[k]) begin
                    if (tmo[k] == TMO_LAST) begin
                        digit_valid[k] <= 1'b0;
                    end
                    if (tmo[k] != TMO_MAX) begin
                        tmo[k] <= tmo[k] + TW'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: vector table, directed scan sequences and
// random scanning against a run-length based reference model.
module tb_seg_scan_capture;
    localparam int N_DIG       = 4;
    localparam int STABLE_CYC  = 4;
    localparam int TIMEOUT_CYC = 1024;

    logic        clk_out = 1'b0;
    logic        rst     = 1'b1;
    logic [3:0]  an_n    = 4'hF;
    logic [6:0]  seg_n   = 7'h7F;
    logic        dp_n    = 1'b1;
    logic [15:0] digit_code;
    logic [3:0]  digit_dp;
    logic [3:0]  digit_valid;
    logic        frame_done;
    logic        err_multi;

    seg_scan_capture #(
        .N_DIG      (N_DIG),
        .STABLE_CYC (STABLE_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk_out    (clk_out),
        .rst        (rst),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .digit_code (digit_code),
        .digit_dp   (digit_dp),
        .digit_valid(digit_valid),
        .frame_done (frame_done),
        .err_multi  (err_multi)
    );

    always #5 clk_out = ~clk_out;

    int total  = 0;
    int bad    = 0;
    int edge_n = 0;

    logic [6:0]  pat [16];
    logic [15:0] m_code;
    logic [3:0]  m_dp;
    logic [3:0]  m_valid;
    logic [3:0]  mask;
    logic        m_frame;
    logic        m_err;
    int          cap_t [4];
    logic [11:0] last_v;
    logic [11:0] pend_v;
    int          run;
    int          pend_at;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dpn;
        int         slot;
        logic [3:0] code;
        logic       valid;
        logic       dp;
    } vec_t;
    vec_t vec [13];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic apply_cap(input logic [11:0] v);
        logic [3:0] lows;
        int k;
        int found;
        lows = ~v[11:8];
        if ($countones(lows) == 1) begin
            k = 0;
            for (int i = 0; i < 4; i++) if (lows[i]) k = i;
            m_dp[k] = ~v[0];
            found = -1;
            for (int i = 0; i < 16; i++) if (pat[i] == ~v[7:1]) found = i;
            if (found >= 0) begin
                m_code[4*k +: 4] = 4'(found);
                m_valid[k] = 1'b1;
                mask[k] = 1'b1;
                cap_t[k] = edge_n;
            end else begin
                m_code[4*k +: 4] = 4'h0;
                m_valid[k] = 1'b0;
            end
        end else if ($countones(lows) > 1) begin
            m_err = 1'b1;
        end
    endtask

    // A pattern sampled STABLE_CYC edges in a row shows up two edges later.
    task automatic model_edge();
        logic [11:0] v;
        if (rst) begin
            m_code = '0; m_dp = '0; m_valid = '0; mask = '0;
            m_frame = 1'b0; m_err = 1'b0; run = 0; pend_at = -1;
            return;
        end
        m_frame = (mask == 4'hF);
        if (m_frame) mask = '0;
        m_err = 1'b0;
        for (int k = 0; k < 4; k++)
            if (m_valid[k] && (edge_n - cap_t[k] >= TIMEOUT_CYC)) m_valid[k] = 1'b0;
        if (pend_at == edge_n) begin
            apply_cap(pend_v);
            pend_at = -1;
        end
        v = {an_n, seg_n, dp_n};
        if (run > 0 && v == last_v) run++;
        else run = 1;
        last_v = v;
        if (run == STABLE_CYC) begin
            pend_at = edge_n + 2;
            pend_v = v;
        end
    endtask

    task automatic step(input logic r, input logic [3:0] a,
                        input logic [6:0] s, input logic d);
        rst = r; an_n = a; seg_n = s; dp_n = d;
        @(posedge clk_out);
        edge_n++;
        model_edge();
        #1;
        chk("model", {6'd0, digit_code, digit_dp, digit_valid, frame_done, err_multi},
            {6'd0, m_code, m_dp, m_valid, m_frame, m_err});
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'hF, 7'h7F, 1'b1);
    endtask

    initial begin
        int nf;
        int ne;
        int cap_e;
        int fall;
        logic [3:0] a;
        logic [3:0] an_opts [7];
        logic [6:0] sg;

        pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        an_opts = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hF, 4'hC, 4'h5};
        vec[0]  = '{4'hE, ~7'h06, 1'b1, 0, 4'h1, 1'b1, 1'b0};
        vec[1]  = '{4'hD, ~7'h5B, 1'b0, 1, 4'h2, 1'b1, 1'b1};
        vec[2]  = '{4'hB, ~7'h4F, 1'b1, 2, 4'h3, 1'b1, 1'b0};
        vec[3]  = '{4'h7, ~7'h77, 1'b0, 3, 4'hA, 1'b1, 1'b1};
        vec[4]  = '{4'hE, ~7'h7C, 1'b1, 0, 4'hB, 1'b1, 1'b0};
        vec[5]  = '{4'hD, ~7'h39, 1'b1, 1, 4'hC, 1'b1, 1'b0};
        vec[6]  = '{4'hB, ~7'h5E, 1'b0, 2, 4'hD, 1'b1, 1'b1};
        vec[7]  = '{4'h7, ~7'h79, 1'b1, 3, 4'hE, 1'b1, 1'b0};
        vec[8]  = '{4'hE, ~7'h71, 1'b1, 0, 4'hF, 1'b1, 1'b0};
        vec[9]  = '{4'hD, ~7'h00, 1'b1, 1, 4'h0, 1'b0, 1'b0};
        vec[10] = '{4'hB, ~7'h7F, 1'b0, 2, 4'h8, 1'b1, 1'b1};
        vec[11] = '{4'h7, ~7'h6D, 1'b1, 3, 4'h5, 1'b1, 1'b0};
        vec[12] = '{4'hE, ~7'h12, 1'b1, 0, 4'h0, 1'b0, 1'b0};
        m_code = '0; m_dp = '0; m_valid = '0; mask = '0;
        m_frame = 1'b0; m_err = 1'b0; run = 0; pend_at = -1;
        last_v = '1; pend_v = '1;
        for (int k = 0; k < 4; k++) cap_t[k] = 0;

        step(1'b1, 4'hF, 7'h7F, 1'b1);
        step(1'b1, 4'hF, 7'h7F, 1'b1);
        chk("rst_out", {6'd0, digit_code, digit_dp, digit_valid, frame_done, err_multi}, 0);
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 4'hF, 7'h7F, 1'b1);
            chk("idle_pulse", {frame_done, err_multi}, 0);
        end

        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 4'hE, ~7'h06, 1'b1);
            chk("t2_valid", digit_valid, (i >= 6) ? 4'b0001 : 4'b0000);
            chk("t2_code", digit_code[3:0], (i >= 6) ? 4'h1 : 4'h0);
        end

        nf = 0;
        for (int d = 0; d < 4; d++) begin
            a = ~(4'b0001 << d);
            sg = (d == 0) ? ~7'h06 : (d == 1) ? ~7'h5B : (d == 2) ? ~7'h4F : ~7'h77;
            for (int i = 0; i < 8; i++) begin
                step(1'b0, a, sg, 1'b1);
                nf += int'(frame_done);
            end
            for (int i = 0; i < 2; i++) begin
                step(1'b0, 4'hF, 7'h7F, 1'b1);
                nf += int'(frame_done);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'hF, 7'h7F, 1'b1);
            nf += int'(frame_done);
        end
        chk("t3_code", digit_code, 16'hA321);
        chk("t3_valid", digit_valid, 4'hF);
        chk("t3_frames", nf, 1);

        for (int i = 0; i < 10; i++) begin
            step(1'b0, 4'hE, (i < 2) ? ~7'h5B : ~7'h06, 1'b1);
            chk("t4_slot0", digit_code[3:0], 4'h1);
        end

        ne = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'hC, ~7'h3F, 1'b1);
            ne += int'(err_multi);
        end
        chk("t5_err_cnt", ne, 1);
        chk("t5_valid", digit_valid, 4'hF);
        blank(2);
        for (int i = 0; i < 8; i++) step(1'b0, 4'hD, ~7'h00, 1'b1);
        blank(2);
        chk("t5_v1", digit_valid, 4'b1101);
        chk("t5_c1", digit_code[7:4], 4'h0);

        cap_e = -1;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'hE, ~7'h4F, 1'b1);
            if (cap_e < 0 && digit_code[3:0] == 4'h3) cap_e = edge_n;
        end
        fall = -1;
        for (int i = 0; i < 1100 && fall < 0; i++) begin
            step(1'b0, 4'hF, 7'h7F, 1'b1);
            if (!digit_valid[0]) fall = edge_n;
        end
        chk("t6_gap", fall - cap_e, TIMEOUT_CYC);
        chk("t6_code_kept", digit_code[3:0], 4'h3);
        for (int i = 0; i < 4; i++) step(1'b0, 4'hB, ~7'h66, 1'b1);
        step(1'b1, 4'hB, ~7'h66, 1'b1);
        step(1'b1, 4'hB, ~7'h66, 1'b1);
        chk("t6_rst_out", {6'd0, digit_code, digit_dp, digit_valid, frame_done, err_multi}, 0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 4'hF, 7'h7F, 1'b1);
            chk("t6_after_rst", digit_valid, 4'h0);
        end

        for (int r = 0; r < 13; r++) begin
            for (int i = 0; i < 7; i++) step(1'b0, vec[r].an, vec[r].seg, vec[r].dpn);
            blank(2);
            chk("vec_code", digit_code[4*vec[r].slot +: 4], vec[r].code);
            chk("vec_valid", digit_valid[vec[r].slot], vec[r].valid);
            chk("vec_dp", digit_dp[vec[r].slot], vec[r].dp);
        end

        for (int b = 0; b < 80; b++) begin
            int hold;
            logic d;
            a = an_opts[$urandom_range(0, 6)];
            sg = ($urandom_range(0, 3) != 0) ? ~pat[$urandom_range(0, 15)]
                                             : 7'($urandom);
            d = 1'($urandom);
            hold = $urandom_range(1, 7);
            for (int i = 0; i < hold; i++)
                step(($urandom_range(0, 60) == 0) ? 1'b1 : 1'b0, a, sg, d);
        end
        blank(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
